// File: rtl/inst_mem_pipe.sv
// Pipelined instruction memory: byte array read on accept, LATENCY-cycle registered response.
// Never back-pressures beyond ce_i/rst_i; a byte load port preloads the array at run time.
module inst_mem_pipe #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_SIZE   = 65536,
  parameter logic [ADDR_WIDTH-1:0] MEM_OFFSET = ADDR_WIDTH'(32'h8000_0000),
  parameter int                    LATENCY    = 1,
  parameter bit                    BIG_ENDIAN = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic                  rsp_err_o,
  input  logic                  ld_we_i,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  input  logic [7:0]            ld_data_i
);

  localparam int                  IDX_W    = $clog2(MEM_SIZE);
  localparam logic [ADDR_WIDTH:0] SIZE_EXT = (ADDR_WIDTH+1)'(MEM_SIZE);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("inst_mem_pipe: DATA_WIDTH must be 32");
    end
    if (MEM_SIZE < 4 || (MEM_SIZE & (MEM_SIZE - 1)) != 0) begin : g_bad_mem_size
      $error("inst_mem_pipe: MEM_SIZE must be a power of two and at least 4");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("inst_mem_pipe: LATENCY must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic                  vld;
    logic                  err;
    logic [DATA_WIDTH-1:0] dat;
  } stage_t;

  logic [7:0]            mem [MEM_SIZE];
  stage_t                pipe [LATENCY];

  logic                  accept;
  logic [ADDR_WIDTH-1:0] fetch_off;
  logic                  fetch_hit;
  logic [IDX_W-1:0]      word_base;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [ADDR_WIDTH-1:0] ld_off;
  logic                  ld_hit;

  assign req_ready_o = ce_i & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;

  // Offset wraps at ADDR_WIDTH, so the lower-bound compare is needed to reject addresses below the window.
  assign fetch_off = addr_i - MEM_OFFSET;
  assign fetch_hit = (addr_i >= MEM_OFFSET) && ({1'b0, fetch_off} < SIZE_EXT);
  assign word_base = {fetch_off[IDX_W-1:2], 2'b00};

  assign ld_off = ld_addr_i - MEM_OFFSET;
  assign ld_hit = (ld_addr_i >= MEM_OFFSET) && ({1'b0, ld_off} < SIZE_EXT);

  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = mem[word_base];
    b1 = mem[word_base | IDX_W'(1)];
    b2 = mem[word_base | IDX_W'(2)];
    b3 = mem[word_base | IDX_W'(3)];
    rd_word = BIG_ENDIAN ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  end

  // Array is not reset; load writes go through even while rst_i is high. Reads above see the pre-edge value.
  always_ff @(posedge clk_i) begin
    if (ld_we_i && ld_hit) begin
      mem[ld_off[IDX_W-1:0]] <= ld_data_i;
    end
  end

  // Stage 0 always takes the current accept, so a request in a flush cycle survives the flush.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0].vld <= accept;
      pipe[0].err <= accept & ~fetch_hit;
      pipe[0].dat <= (accept && fetch_hit) ? rd_word : '0;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i].vld <= pipe[i-1].vld & ~flush_i;
        pipe[i].err <= pipe[i-1].err;
        pipe[i].dat <= pipe[i-1].dat;
      end
    end
  end

  assign rsp_valid_o = pipe[LATENCY-1].vld;
  assign rsp_err_o   = pipe[LATENCY-1].vld & pipe[LATENCY-1].err;
  assign inst_o      = pipe[LATENCY-1].vld ? pipe[LATENCY-1].dat : '0;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: three configurations share one stimulus stream, checked against a cycle-indexed response model.
module tb_inst_mem_pipe;

  localparam logic [31:0] OFS  = 32'h8000_0000;
  localparam int          MSZ  = 65536;
  localparam int          NCYC = 3000;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce, flush, req_valid, ld_we;
  logic [31:0] addr, ld_addr;
  logic [7:0]  ld_data;

  logic        rdy [3];
  logic        rv  [3];
  logic        re  [3];
  logic [31:0] io  [3];

  int lat [3] = '{3, 2, 1};
  bit be  [3] = '{1'b1, 1'b0, 1'b1};

  inst_mem_pipe #(.LATENCY(3), .BIG_ENDIAN(1'b1)) u_l3_be (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(rdy[0]), .addr_i(addr), .rsp_valid_o(rv[0]), .inst_o(io[0]), .rsp_err_o(re[0]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  inst_mem_pipe #(.LATENCY(2), .BIG_ENDIAN(1'b0)) u_l2_le (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(rdy[1]), .addr_i(addr), .rsp_valid_o(rv[1]), .inst_o(io[1]), .rsp_err_o(re[1]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  inst_mem_pipe #(.LATENCY(1), .BIG_ENDIAN(1'b1)) u_l1_be (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .flush_i(flush), .req_valid_i(req_valid),
    .req_ready_o(rdy[2]), .addr_i(addr), .rsp_valid_o(rv[2]), .inst_o(io[2]), .rsp_err_o(re[2]),
    .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data));

  // Reference state: byte image of the array and the expected output of each instance per cycle.
  logic [7:0]  bm [MSZ];
  bit          ev [3][NCYC];
  bit          ee [3][NCYC];
  logic [31:0] ed [3][NCYC];
  int          cyc;
  int          tests;
  int          fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    return (a >= OFS) && ((a - OFS) < MSZ);
  endfunction

  function automatic logic [31:0] model_word(input bit big, input logic [31:0] a);
    int w;
    w = int'((a - OFS) & 32'hFFFF_FFFC);
    if (big) return {bm[w], bm[w+1], bm[w+2], bm[w+3]};
    return {bm[w+3], bm[w+2], bm[w+1], bm[w]};
  endfunction

  // Inputs are already driven; check ready, update the model, clock once, check responses.
  task automatic cycle();
    bit acc;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("L%0d_ready", lat[k]), rdy[k], ce & ~rst);
    acc = req_valid & ce & ~rst;
    if (flush || rst) begin
      for (int k = 0; k < 3; k++)
        for (int d = 1; d <= 4; d++)
          if (cyc + d < NCYC) begin
            ev[k][cyc+d] = 1'b0;
            ee[k][cyc+d] = 1'b0;
            ed[k][cyc+d] = '0;
          end
    end
    if (acc) begin
      for (int k = 0; k < 3; k++) begin
        int t;
        t = cyc + lat[k];
        if (t < NCYC) begin
          ev[k][t] = 1'b1;
          ee[k][t] = !in_win(addr);
          ed[k][t] = in_win(addr) ? model_word(be[k], addr) : 32'h0;
        end
      end
    end
    if (ld_we && in_win(ld_addr)) bm[int'(ld_addr - OFS)] = ld_data;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("L%0d_rsp_valid", lat[k]), rv[k], ev[k][cyc]);
      check($sformatf("L%0d_rsp_err", lat[k]), re[k], ee[k][cyc]);
      check($sformatf("L%0d_inst", lat[k]), io[k], ed[k][cyc]);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit f, input bit v, input logic [31:0] a,
                      input bit we, input logic [31:0] la, input logic [7:0] ld);
    rst = r; ce = c; flush = f; req_valid = v; addr = a;
    ld_we = we; ld_addr = la; ld_data = ld;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
  endtask

  initial begin
    logic [7:0]  pre [4];
    logic [31:0] a, la;
    int          c0;
    tests = 0; fails = 0; cyc = 0;
    pre[0] = 8'h13; pre[1] = 8'h05; pre[2] = 8'h00; pre[3] = 8'h00;
    rst = 1'b1; ce = 1'b0; flush = 1'b0; req_valid = 1'b0; addr = '0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    @(posedge clk);
    #1;

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b1, 1'b0, 1'b1, OFS, 1'b0, 32'h0, 8'h0);

    // Preload first 256 bytes; word at 0x10 stays zero for the read-before-write case
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      if (i < 4) b = pre[i];
      else if (i >= 16 && i < 20) b = 8'h00;
      else b = 8'($urandom);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, OFS + 32'(i), b);
    end

    // Byte order on a known word, with the constant result checked at each instance's latency
    c0 = cyc;
    for (int j = 0; j < 4; j++) begin
      step(1'b0, 1'b1, 1'b0, (j == 0), OFS, 1'b0, 32'h0, 8'h0);
      for (int k = 0; k < 3; k++)
        if (cyc == c0 + lat[k])
          check($sformatf("L%0d_known_word", lat[k]), io[k], be[k] ? 32'h1305_0000 : 32'h0000_0513);
    end

    // Back-to-back fetches
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h4, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h8, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Window edges and ignored low address bits
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFC, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8001_0000, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0006, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_FFFF, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Flush in the cycle of the second accept
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h4, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, OFS + 32'h8, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Load and fetch of the same word in one cycle, then refetch
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h10, 1'b1, OFS + 32'h10, 8'hAA);
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h10, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Out-of-window load must not alias into the array
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h8001_0004, 8'h5A);
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h4, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Reset with fetches in flight and ce low
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS, 1'b0, 32'h0, 8'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, OFS + 32'h4, 1'b0, 32'h0, 8'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, OFS + 32'h8, 1'b1, OFS + 32'h20, 8'h77);
    step(1'b1, 1'b0, 1'b0, 1'b1, OFS + 32'hC, 1'b0, 32'h0, 8'h0);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = OFS - 32'(4 * $urandom_range(1, 64));
      else if (sel == 1) a = OFS + MSZ + 32'($urandom_range(0, 255));
      else if (sel == 2) a = $urandom & 32'h7FFF_FFFF;
      else               a = OFS + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) < 8) la = OFS + 32'($urandom_range(0, 255));
      else                          la = OFS + MSZ + 32'($urandom_range(0, 255));
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 5,
           $urandom_range(0, 99) < 70, a, $urandom_range(0, 99) < 30, la, 8'($urandom));
    end
    idle(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised, pipelined instruction memory for the IF stage. It replaces the combinational ROM with a registered-read byte array and a valid/ready request interface. Read latency is configurable, byte order is selectable, and the block flags accesses outside its address window. A byte-wide load port lets the testbench or boot logic preload the array at run time.

Parameters:
ADDR_WIDTH, 32, width of the fetch and load addresses.
DATA_WIDTH, 32, instruction width; fixed at 32; other values are illegal.
MEM_SIZE, 65536, array size in bytes; must be a power of two and at least 4.
MEM_OFFSET, 32'h8000_0000, byte address that maps to array index 0.
LATENCY, 1, cycles from request accept to response; legal range 1..4.
BIG_ENDIAN, 1, 1 puts byte[a] in inst[31:24]; 0 puts byte[a] in inst[7:0].

Ports:
clk_i  in  1  clock; all logic is on the rising edge.
rst_i  in  1  synchronous reset, active-high.
ce_i  in  1  fetch enable.
flush_i  in  1  discards all in-flight responses (branch or redirect).
req_valid_i  in  1  fetch request valid.
req_ready_o  out  1  request can be accepted.
addr_i  in  ADDR_WIDTH  fetch byte address.
rsp_valid_o  out  1  response valid; held for one cycle only.
inst_o  out  DATA_WIDTH  fetched instruction.
rsp_err_o  out  1  fetch address was outside the window; qualified by rsp_valid_o.
ld_we_i  in  1  load-port byte write enable.
ld_addr_i  in  ADDR_WIDTH  load-port absolute byte address.
ld_data_i  in  8  load-port byte data.

Behaviour:
- Reset: rsp_valid_o=0, inst_o=0, rsp_err_o=0, all pipeline valid bits cleared. The array contents are not reset.
- Reset mid-operation: every in-flight fetch is dropped and no response is issued for it.
- req_ready_o = ce_i & ~rst_i. It is combinational, and there is no other back-pressure.
- A request is accepted when req_valid_i & req_ready_o. One fetch can be accepted per cycle, giving full throughput.
- Address translation: off = addr_i - MEM_OFFSET, computed at ADDR_WIDTH and wrapping. The window is hit when off < MEM_SIZE, evaluated with addr_i >= MEM_OFFSET.
- addr_i[1:0] is ignored. Word index = off[log2(MEM_SIZE)-1:2].
- Array read happens in the accept cycle, and the data enters stage 1.
- Stages 2..LATENCY are plain delay registers carrying {valid, err, data}.
- The response for a request accepted in cycle N appears in cycle N+LATENCY, with rsp_valid_o=1 for exactly that cycle. Responses keep request order.
- Byte assembly with BIG_ENDIAN=1: {m[w], m[w+1], m[w+2], m[w+3]}. With BIG_ENDIAN=0: {m[w+3], m[w+2], m[w+1], m[w]}.
- Out-of-window fetch: rsp_err_o=1 and inst_o=0. No array access is made and the fetch keeps its normal latency slot.
- When rsp_valid_o=0, inst_o=0 and rsp_err_o=0.
- flush_i: on the edge where it is high, all pipeline valid bits are cleared. A request accepted in the same cycle as flush_i is kept, and its response appears LATENCY cycles later.
- ce_i=0 blocks only new accepts. Fetches already in flight still complete.
- Load port: when ld_we_i is high and ld_addr_i is in the window, m[ld_addr_i - MEM_OFFSET] = ld_data_i at the clock edge. Out-of-window load writes are silently ignored. The load port works whatever the state of ce_i.
- A load write and a fetch of the same word in the same cycle: the fetch returns the old byte (read-before-write).
- Load writes are still performed while rst_i is high.

Test Plan:
1. Preload via the load port: bytes 13,05,00,00 at 0x8000_0000..3 (order 13 at 0x8000_0000, 05 at 0x8000_0001, 00, 00). Fetch 0x8000_0000 with BIG_ENDIAN=1 -> inst_o=0x1305_0000. With BIG_ENDIAN=0 -> inst_o=0x0000_0513.
2. LATENCY=3, fetches back to back to 0x8000_0000, _0004, _0008 in cycles 0-2 -> rsp_valid_o high in cycles 3-5, data in order, rsp_err_o=0.
3. Fetch 0x7FFF_FFFC and 0x8001_0000 (MEM_SIZE=65536) -> rsp_err_o=1, inst_o=0, both at normal latency. Fetch 0x8000_0006 -> returns the word at 0x8000_0004.
4. LATENCY=2, fetches accepted in cycles 0 and 1, flush_i high in cycle 1 -> the cycle-0 fetch is dropped; the cycle-1 fetch responds in cycle 3.
5. In the same cycle, load-write 0xAA to 0x8000_0010 and fetch 0x8000_0010 (old word 0) -> the fetch returns 0. A second fetch returns 0xAA00_0000 (BIG_ENDIAN=1).
6. rst_i high with 2 fetches in flight and ce_i=0 -> no rsp_valid_o, req_ready_o=0, all outputs 0 after the first reset edge.
